// File: rtl/mem_defs.sv
// Shared definitions for the data access unit.
//   acc_t   : request size encodings carried on accessType
//   IO_SEL  : value of address bits [17:16] that selects the IO region
//   state_t : sequencer state encoding
package mem_defs;

  typedef enum logic [1:0] {
    ACC_NONE = 2'b00,
    ACC_BYTE = 2'b01,
    ACC_HALF = 2'b10,
    ACC_WORD = 2'b11
  } acc_t;

  localparam logic [1:0] IO_SEL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_XFER  = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

endpackage

// File: rtl/data_access_unit.sv
// data_access_unit: serialises one byte/half/word load or store onto the
// 8-bit memory bus, one byte per granted cycle, little-endian.
// Ports:
//   clockIn, resetIn (async, active-high), readyIn (global enable), clearIn (flush)
//   accessType/readWriteIn/dataAddr/dataOut : request pulse from the load/store buffer
//   dataValid/dataIn  : one-cycle load-done pulse with zero-extended result
//   dataWriteSuc      : one-cycle store-done pulse
//   memReq/memGrant/memAddr/memWr/memOut/memIn : arbiter/RAM bus
//   ioBufferFull      : IO output FIFO full, stalls IO stores per byte
module data_access_unit
  import mem_defs::*;
(
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        readyIn,
  input  logic        clearIn,
  input  logic [1:0]  accessType,
  input  logic        readWriteIn,
  input  logic [31:0] dataAddr,
  input  logic [31:0] dataOut,
  output logic        dataValid,
  output logic [31:0] dataIn,
  output logic        dataWriteSuc,
  output logic        memReq,
  input  logic        memGrant,
  output logic [31:0] memAddr,
  output logic        memWr,
  output logic [7:0]  memOut,
  input  logic [7:0]  memIn,
  input  logic        ioBufferFull
);

  state_t      state, state_n;
  logic        op_rd;
  logic [31:0] base;
  logic [31:0] sdata;
  logic [2:0]  n_bytes;
  logic [2:0]  k;
  logic [1:0]  cap_cnt;
  logic        cap_pend;
  logic [31:0] asm_q;

  logic        xfer, req_ok, stall, issue, last, abort, vld_n, suc_n;
  logic [2:0]  req_n;
  logic [31:0] addr_c, asm_n;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    xfer   = (state == ST_XFER);
    addr_c = base + {29'd0, k};
    stall  = !op_rd && (addr_c[17:16] == IO_SEL) && ioBufferFull;
    issue  = xfer && memGrant && !stall;
    last   = issue && (k == n_bytes - 3'd1);
    // Only loads are abortable; a committed store always runs to completion.
    abort  = clearIn && op_rd && (state != ST_IDLE);
    // A load arriving together with a flush belongs to the flushed path.
    req_ok = (accessType != ACC_NONE) && !(clearIn && readWriteIn);

    case (accessType)
      ACC_BYTE: req_n = 3'd1;
      ACC_HALF: req_n = 3'd2;
      default:  req_n = 3'd4;
    endcase

    // Byte issued last cycle is on memIn now; merge it so DRAIN can hand the
    // complete word straight to dataIn.
    asm_n = asm_q;
    if (cap_pend) asm_n[{cap_cnt, 3'b000} +: 8] = memIn;

    state_n = state;
    vld_n   = 1'b0;
    suc_n   = 1'b0;
    case (state)
      ST_IDLE:  if (req_ok) state_n = ST_XFER;
      ST_XFER: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (last) begin
          state_n = op_rd ? ST_DRAIN : ST_IDLE;
          suc_n   = !op_rd;
        end
      end
      ST_DRAIN: begin
        state_n = ST_IDLE;
        vld_n   = !abort;
      end
      default:  state_n = ST_IDLE;
    endcase

    memReq  = xfer;
    memAddr = (xfer && memGrant) ? addr_c : 32'd0;
    memWr   = xfer && memGrant && !op_rd && !stall;
    memOut  = (xfer && memGrant && !op_rd) ? sdata[{k[1:0], 3'b000} +: 8] : 8'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      state        <= ST_IDLE;
      op_rd        <= 1'b0;
      base         <= '0;
      sdata        <= '0;
      n_bytes      <= '0;
      k            <= '0;
      cap_cnt      <= '0;
      cap_pend     <= 1'b0;
      asm_q        <= '0;
      dataValid    <= 1'b0;
      dataWriteSuc <= 1'b0;
      dataIn       <= '0;
    end else if (readyIn) begin
      state        <= state_n;
      dataValid    <= vld_n;
      dataWriteSuc <= suc_n;
      if (vld_n) dataIn <= asm_n;

      if (state == ST_IDLE && req_ok) begin
        op_rd    <= readWriteIn;
        base     <= dataAddr;
        sdata    <= dataOut;
        n_bytes  <= req_n;
        k        <= '0;
        cap_cnt  <= '0;
        cap_pend <= 1'b0;
        asm_q    <= '0;
      end else begin
        if (issue) k <= k + 3'd1;
        if (cap_pend) cap_cnt <= cap_cnt + 2'd1;
        asm_q    <= asm_n;
        // Clearing the pending flag on abort drops any late memIn byte.
        cap_pend <= issue && op_rd && !abort;
      end
    end
  end

endmodule

// File: tb/tb_data_access_unit.sv
module tb_data_access_unit;
  import mem_defs::*;

  logic        clockIn = 1'b0;
  logic        resetIn, readyIn, clearIn, readWriteIn, ioBufferFull;
  logic [1:0]  accessType;
  logic [31:0] dataAddr, dataOut;
  logic        dataValid, dataWriteSuc, memReq, memGrant, memWr;
  logic [31:0] dataIn, memAddr;
  logic [7:0]  memOut, memIn;
  logic        grant_en;

  int checks = 0;
  int failures = 0;

  always #5 clockIn = ~clockIn;

  data_access_unit dut (
    .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn),
    .accessType(accessType), .readWriteIn(readWriteIn), .dataAddr(dataAddr),
    .dataOut(dataOut), .dataValid(dataValid), .dataIn(dataIn),
    .dataWriteSuc(dataWriteSuc), .memReq(memReq), .memGrant(memGrant),
    .memAddr(memAddr), .memWr(memWr), .memOut(memOut), .memIn(memIn),
    .ioBufferFull(ioBufferFull)
  );

  // Arbiter: same-cycle grant, gated by the bench.
  assign memGrant = memReq && grant_en;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h11;
      32'h0000_0101: return 8'h22;
      32'h0000_0102: return 8'h33;
      32'h0000_0103: return 8'h44;
      32'h0001_FFFF: return 8'hAA;
      32'h0002_0000: return 8'hBB;
      default:       return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // RAM read data appears one cycle after the address.
  initial memIn = 8'h00;
  always @(posedge clockIn) memIn <= ram_byte(memAddr);

  // Requests are only legal while the unit is idle.
  always @(negedge clockIn)
    if (!resetIn && readyIn && accessType != ACC_NONE)
      assert (dut.state == ST_IDLE) else $error("request while busy");

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Advance to the next cycle; inputs are driven right after the edge.
  task automatic next();
    @(posedge clockIn);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  task automatic request(input logic [1:0] acc, input logic rd,
                         input logic [31:0] a, input logic [31:0] d);
    accessType  = acc;
    readWriteIn = rd;
    dataAddr    = a;
    dataOut     = d;
  endtask

  initial begin
    resetIn = 1'b1; readyIn = 1'b1; clearIn = 1'b0; ioBufferFull = 1'b0;
    grant_en = 1'b1;
    request(ACC_NONE, 1'b0, 32'd0, 32'd0);
    next(); next();
    settle();
    check("rst_valid", {31'd0, dataValid}, 32'd0);
    check("rst_suc", {31'd0, dataWriteSuc}, 32'd0);
    check("rst_datain", dataIn, 32'd0);
    check("rst_req", {31'd0, memReq}, 32'd0);
    check("rst_addr", memAddr, 32'd0);
    check("rst_wr", {31'd0, memWr}, 32'd0);
    check("rst_out", {24'd0, memOut}, 32'd0);
    next();
    resetIn = 1'b0;
    next();

    // Word load at 0x100, immediate grant.
    request(ACC_WORD, 1'b1, 32'h100, 32'd0);
    settle();
    check("t1_req_c0", {31'd0, memReq}, 32'd0);
    next();
    request(ACC_NONE, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t1_req", {31'd0, memReq}, 32'd1);
      check("t1_addr", memAddr, 32'h100 + i);
      check("t1_wr", {31'd0, memWr}, 32'd0);
      next();
    end
    settle();
    check("t1_drain_req", {31'd0, memReq}, 32'd0);
    check("t1_drain_vld", {31'd0, dataValid}, 32'd0);
    next(); settle();
    check("t1_vld", {31'd0, dataValid}, 32'd1);
    check("t1_data", dataIn, 32'h4433_2211);
    check("t1_suc", {31'd0, dataWriteSuc}, 32'd0);
    next(); settle();
    check("t1_vld_end", {31'd0, dataValid}, 32'd0);
    next();

    // Byte store to IO with the FIFO full for 3 cycles.
    request(ACC_BYTE, 1'b0, 32'h0003_0000, 32'h0000_00A5);
    ioBufferFull = 1'b1;
    next();
    request(ACC_NONE, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t2_stall_req", {31'd0, memReq}, 32'd1);
      check("t2_stall_wr", {31'd0, memWr}, 32'd0);
      next();
    end
    ioBufferFull = 1'b0;
    settle();
    check("t2_wr", {31'd0, memWr}, 32'd1);
    check("t2_addr", memAddr, 32'h0003_0000);
    check("t2_out", {24'd0, memOut}, 32'h0000_00A5);
    check("t2_suc_early", {31'd0, dataWriteSuc}, 32'd0);
    next(); settle();
    check("t2_suc", {31'd0, dataWriteSuc}, 32'd1);
    check("t2_req_off", {31'd0, memReq}, 32'd0);
    next(); settle();
    check("t2_suc_end", {31'd0, dataWriteSuc}, 32'd0);
    next();

    // Half load across a 64 KiB boundary with a 2-cycle grant gap.
    request(ACC_HALF, 1'b1, 32'h0001_FFFF, 32'd0);
    next();
    request(ACC_NONE, 1'b0, 32'd0, 32'd0);
    settle();
    check("t3_addr0", memAddr, 32'h0001_FFFF);
    next();
    grant_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("t3_gap_req", {31'd0, memReq}, 32'd1);
      check("t3_gap_addr", memAddr, 32'd0);
      next();
    end
    grant_en = 1'b1;
    settle();
    check("t3_addr1", memAddr, 32'h0002_0000);
    next(); settle();
    check("t3_drain_req", {31'd0, memReq}, 32'd0);
    next(); settle();
    check("t3_vld", {31'd0, dataValid}, 32'd1);
    check("t3_data", dataIn, 32'h0000_BBAA);
    next();

    // Flush during the second byte of a word load, then a fresh byte load.
    request(ACC_WORD, 1'b1, 32'h0000_0200, 32'd0);
    next();
    request(ACC_NONE, 1'b0, 32'd0, 32'd0);
    next();
    clearIn = 1'b1;
    settle();
    check("t4_addr1", memAddr, 32'h0000_0201);
    next();
    clearIn = 1'b0;
    settle();
    check("t4_req_off", {31'd0, memReq}, 32'd0);
    request(ACC_BYTE, 1'b1, 32'h0000_0101, 32'd0);
    next();
    request(ACC_NONE, 1'b0, 32'd0, 32'd0);
    settle();
    check("t4_new_addr", memAddr, 32'h0000_0101);
    check("t4_no_vld_a", {31'd0, dataValid}, 32'd0);
    next(); settle();
    check("t4_no_vld_b", {31'd0, dataValid}, 32'd0);
    next(); settle();
    check("t4_vld", {31'd0, dataValid}, 32'd1);
    check("t4_data", dataIn, 32'h0000_0022);
    next();

    // Flush during the second byte of a word store: store still completes.
    request(ACC_WORD, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF);
    next();
    request(ACC_NONE, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] word;
      word = 32'hDEAD_BEEF;
      clearIn = (i == 1);
      settle();
      check("t5_wr", {31'd0, memWr}, 32'd1);
      check("t5_addr", memAddr, 32'h0000_0400 + i);
      check("t5_out", {24'd0, memOut}, {24'd0, word[i*8 +: 8]});
      next();
    end
    clearIn = 1'b0;
    settle();
    check("t5_suc", {31'd0, dataWriteSuc}, 32'd1);
    next();

    // Back-to-back: store pulse in the dataValid cycle, then a 2-cycle freeze.
    request(ACC_BYTE, 1'b1, 32'h0000_0103, 32'd0);
    next();
    request(ACC_NONE, 1'b0, 32'd0, 32'd0);
    next(); next();
    settle();
    check("t6_vld", {31'd0, dataValid}, 32'd1);
    check("t6_ld_data", dataIn, 32'h0000_0044);
    request(ACC_HALF, 1'b0, 32'h0000_0500, 32'h0000_1234);
    next();
    request(ACC_NONE, 1'b0, 32'd0, 32'd0);
    settle();
    check("t6_addr0", memAddr, 32'h0000_0500);
    check("t6_out0", {24'd0, memOut}, 32'h0000_0034);
    check("t6_vld_end", {31'd0, dataValid}, 32'd0);
    next();
    readyIn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("t6_frz_addr", memAddr, 32'h0000_0501);
      check("t6_frz_out", {24'd0, memOut}, 32'h0000_0012);
      check("t6_frz_suc", {31'd0, dataWriteSuc}, 32'd0);
      next();
    end
    readyIn = 1'b1;
    settle();
    check("t6_addr1", memAddr, 32'h0000_0501);
    check("t6_suc_early", {31'd0, dataWriteSuc}, 32'd0);
    next(); settle();
    check("t6_suc", {31'd0, dataWriteSuc}, 32'd1);
    check("t6_req_off", {31'd0, memReq}, 32'd0);
    next(); settle();
    check("t6_suc_end", {31'd0, dataWriteSuc}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
